// File: rtl/op_sequencer.sv
// op_sequencer: microsequencer that steps the datapath control strobes through
// the fetch (T0..T2) and execute (T3..T6) phases of one register-register ALU
// instruction, started by a start pulse and closed by a done pulse.
//
// Optional build macro: R0_ZERO_EN -- R0 is hardwired to zero, so reg_in[0] and
// reg_out[0] are never asserted. When undefined, R0 is an ordinary register.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-low reset
//   start        begin one instruction (sampled only in IDLE)
//   mem_rdy      memory read complete, qualifies T1
//   ir           IR contents from the datapath, valid from T3
//   reg_out      one-hot register-to-bus enables
//   reg_in       one-hot register load enables
//   pc_out..lo_in  single-bit datapath strobes
//   alu_op       one-hot ALU select
//   busy         high from T0 through the final step
//   done         one-cycle pulse in the final step
//   illegal      one-cycle pulse with done on an undecodable instruction
//   instr_count  completed-instruction counter (wraps)
module op_sequencer #(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                mem_rdy,
    input  logic [31:0]         ir,
    output logic [NUM_REGS-1:0] reg_out,
    output logic [NUM_REGS-1:0] reg_in,
    output logic                pc_out,
    output logic                pc_in,
    output logic                inc_pc,
    output logic                mar_in,
    output logic                mdr_in,
    output logic                mdr_out,
    output logic                read,
    output logic                ir_in,
    output logic                y_in,
    output logic                z_in,
    output logic                zlow_out,
    output logic                zhigh_out,
    output logic                hi_in,
    output logic                lo_in,
    output logic [12:0]         alu_op,
    output logic                busy,
    output logic                done,
    output logic                illegal,
    output logic [CNT_W-1:0]    instr_count
);

    localparam int unsigned ALU_W   = 13;
    localparam int unsigned RIDX_W  = 4;

    localparam int unsigned ALU_AND  = 0;
    localparam int unsigned ALU_OR   = 1;
    localparam int unsigned ALU_ADD  = 2;
    localparam int unsigned ALU_SUB  = 3;
    localparam int unsigned ALU_MUL  = 4;
    localparam int unsigned ALU_DIV  = 5;
    localparam int unsigned ALU_SHR  = 6;
    localparam int unsigned ALU_SHRA = 7;
    localparam int unsigned ALU_SHL  = 8;
    localparam int unsigned ALU_ROR  = 9;
    localparam int unsigned ALU_ROL  = 10;
    localparam int unsigned ALU_NEG  = 11;
    localparam int unsigned ALU_NOT  = 12;

    typedef enum logic [3:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_BIN4,
        S_BIN5,
        S_UN4,
        S_MD4,
        S_MD5,
        S_MD6
    } state_t;

    typedef enum logic [1:0] {
        CLS_BIN,
        CLS_UN,
        CLS_MD,
        CLS_BAD
    } cls_t;

    state_t              state_q, state_d;
    logic [RIDX_W-1:0]   ra_q, rb_q, rc_q;
    logic [ALU_W-1:0]    alu_q;
    logic [CNT_W-1:0]    instr_count_q, instr_count_d;

    logic [4:0]          dec_op;
    logic [RIDX_W-1:0]   dec_ra, dec_rb, dec_rc;
    cls_t                dec_cls;
    logic [ALU_W-1:0]    dec_alu;
    logic                dec_bad;
    logic                ir_unused;

    assign dec_op    = ir[31:27];
    assign dec_ra    = ir[26:23];
    assign dec_rb    = ir[22:19];
    assign dec_rc    = ir[18:15];
    assign ir_unused = ^ir[14:0];

    // Register field lies inside the implemented register file.
    function automatic logic reg_ok(input logic [RIDX_W-1:0] r);
        return {1'b0, r} < 5'(NUM_REGS);
    endfunction

    // One-hot register select.
    function automatic logic [NUM_REGS-1:0] reg_sel(input logic [RIDX_W-1:0] r);
        logic [NUM_REGS-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (RIDX_W'(i) == r) v[i] = 1'b1;
        end
        return v;
    endfunction

    // Opcode decode: instruction class and ALU select.
    always_comb begin : decode
        dec_cls = CLS_BAD;
        dec_alu = '0;
        case (dec_op)
            5'd3:  begin dec_cls = CLS_BIN; dec_alu[ALU_ADD]  = 1'b1; end
            5'd4:  begin dec_cls = CLS_BIN; dec_alu[ALU_SUB]  = 1'b1; end
            5'd5:  begin dec_cls = CLS_BIN; dec_alu[ALU_AND]  = 1'b1; end
            5'd6:  begin dec_cls = CLS_BIN; dec_alu[ALU_OR]   = 1'b1; end
            5'd7:  begin dec_cls = CLS_BIN; dec_alu[ALU_ROR]  = 1'b1; end
            5'd8:  begin dec_cls = CLS_BIN; dec_alu[ALU_ROL]  = 1'b1; end
            5'd9:  begin dec_cls = CLS_BIN; dec_alu[ALU_SHR]  = 1'b1; end
            5'd10: begin dec_cls = CLS_BIN; dec_alu[ALU_SHRA] = 1'b1; end
            5'd11: begin dec_cls = CLS_BIN; dec_alu[ALU_SHL]  = 1'b1; end
            5'd15: begin dec_cls = CLS_MD;  dec_alu[ALU_MUL]  = 1'b1; end
            5'd16: begin dec_cls = CLS_MD;  dec_alu[ALU_DIV]  = 1'b1; end
            5'd17: begin dec_cls = CLS_UN;  dec_alu[ALU_NEG]  = 1'b1; end
            5'd18: begin dec_cls = CLS_UN;  dec_alu[ALU_NOT]  = 1'b1; end
            default: begin dec_cls = CLS_BAD; dec_alu = '0; end
        endcase
        // Rc is only read by binary ops.
        dec_bad = (dec_cls == CLS_BAD) || !reg_ok(dec_ra) || !reg_ok(dec_rb)
                  || ((dec_cls == CLS_BIN) && !reg_ok(dec_rc));
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge reset) begin : state_reg
        if (!reset) begin
            state_q       <= S_IDLE;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            instr_count_q <= instr_count_d;
        end
    end

    // Decoded fields held for the execute steps after T3.
    always_ff @(posedge clk or negedge reset) begin : field_reg
        if (!reset) begin
            ra_q  <= '0;
            rb_q  <= '0;
            rc_q  <= '0;
            alu_q <= '0;
        end else if (state_q == S_T3) begin
            ra_q  <= dec_ra;
            rb_q  <= dec_rb;
            rc_q  <= dec_rc;
            alu_q <= dec_alu;
        end
    end

    // Next state and Moore strobe decode.
    always_comb begin : fsm_comb
        state_d   = state_q;
        reg_out   = '0;
        reg_in    = '0;
        pc_out    = 1'b0;
        pc_in     = 1'b0;
        inc_pc    = 1'b0;
        mar_in    = 1'b0;
        mdr_in    = 1'b0;
        mdr_out   = 1'b0;
        read      = 1'b0;
        ir_in     = 1'b0;
        y_in      = 1'b0;
        z_in      = 1'b0;
        zlow_out  = 1'b0;
        zhigh_out = 1'b0;
        hi_in     = 1'b0;
        lo_in     = 1'b0;
        alu_op    = '0;
        busy      = (state_q != S_IDLE);
        done      = 1'b0;
        illegal   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_T0;
            end
            S_T0: begin
                pc_out  = 1'b1;
                mar_in  = 1'b1;
                inc_pc  = 1'b1;
                z_in    = 1'b1;
                state_d = S_T1;
            end
            S_T1: begin
                zlow_out = 1'b1;
                pc_in    = 1'b1;
                read     = 1'b1;
                mdr_in   = 1'b1;
                if (mem_rdy) state_d = S_T2;
            end
            S_T2: begin
                mdr_out = 1'b1;
                ir_in   = 1'b1;
                state_d = S_T3;
            end
            S_T3: begin
                if (dec_bad) begin
                    done    = 1'b1;
                    illegal = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    case (dec_cls)
                        CLS_BIN: begin
                            reg_out = reg_sel(dec_rb);
                            y_in    = 1'b1;
                            state_d = S_BIN4;
                        end
                        CLS_UN: begin
                            reg_out = reg_sel(dec_rb);
                            alu_op  = dec_alu;
                            z_in    = 1'b1;
                            state_d = S_UN4;
                        end
                        CLS_MD: begin
                            reg_out = reg_sel(dec_ra);
                            y_in    = 1'b1;
                            state_d = S_MD4;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            S_BIN4: begin
                reg_out = reg_sel(rc_q);
                alu_op  = alu_q;
                z_in    = 1'b1;
                state_d = S_BIN5;
            end
            S_BIN5, S_UN4: begin
                zlow_out = 1'b1;
                reg_in   = reg_sel(ra_q);
                done     = 1'b1;
                state_d  = S_IDLE;
            end
            S_MD4: begin
                reg_out = reg_sel(rb_q);
                alu_op  = alu_q;
                z_in    = 1'b1;
                state_d = S_MD5;
            end
            S_MD5: begin
                zlow_out = 1'b1;
                lo_in    = 1'b1;
                state_d  = S_MD6;
            end
            S_MD6: begin
                zhigh_out = 1'b1;
                hi_in     = 1'b1;
                done      = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

`ifdef R0_ZERO_EN
        // R0 reads as zero by leaving the bus undriven, and is never written.
        reg_out[0] = 1'b0;
        reg_in[0]  = 1'b0;
`else
        reg_out = reg_out;
        reg_in  = reg_in;
`endif

        // Every final step, legal or not, counts as a completed instruction.
        instr_count_d = done ? (instr_count_q + CNT_W'(1)) : instr_count_q;
    end

    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_op_sequencer.sv
// Testbench for op_sequencer: stimulus drives instructions and pushes the
// expected per-cycle strobe set into a scoreboard queue; a monitor on the
// falling edge pops and compares whenever the sequencer reports busy.
module tb_op_sequencer;

    localparam int NR = 12;
    localparam int CW = 4;

    localparam int PC_OUT = 0, PC_IN = 1, INC_PC = 2, MAR_IN = 3, MDR_IN = 4;
    localparam int MDR_OUT = 5, READ = 6, IR_IN = 7, Y_IN = 8, Z_IN = 9;
    localparam int ZLOW = 10, ZHIGH = 11, HI_IN = 12, LO_IN = 13;

    typedef struct packed {
        logic [NR-1:0] rout;
        logic [NR-1:0] rin;
        logic [13:0]   stb;
        logic [12:0]   alu;
        logic          done;
        logic          ill;
        logic [CW-1:0] cnt;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset, start, mem_rdy;
    logic [31:0]   ir;
    logic [NR-1:0] reg_out, reg_in;
    logic pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, read, ir_in;
    logic y_in, z_in, zlow_out, zhigh_out, hi_in, lo_in;
    logic [12:0]   alu_op;
    logic          busy, done, illegal;
    logic [CW-1:0] instr_count;

    exp_t          sb_q[$];
    exp_t          steps[$];
    logic [CW-1:0] n_done;
    logic          end_req;

    int            checks = 0;
    int            errs   = 0;
    logic [CW-1:0] idle_cnt = '0;

    always #5 clk = ~clk;

    op_sequencer #(.NUM_REGS(NR), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .mem_rdy(mem_rdy), .ir(ir),
        .reg_out(reg_out), .reg_in(reg_in),
        .pc_out(pc_out), .pc_in(pc_in), .inc_pc(inc_pc), .mar_in(mar_in),
        .mdr_in(mdr_in), .mdr_out(mdr_out), .read(read), .ir_in(ir_in),
        .y_in(y_in), .z_in(z_in), .zlow_out(zlow_out), .zhigh_out(zhigh_out),
        .hi_in(hi_in), .lo_in(lo_in), .alu_op(alu_op),
        .busy(busy), .done(done), .illegal(illegal), .instr_count(instr_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t blank();
        exp_t r;
        r = '0;
        r.cnt = n_done;
        return r;
    endfunction

    function automatic logic [NR-1:0] oh(input int r);
        logic [NR-1:0] v;
        v = '0;
        v[r] = 1'b1;
`ifdef R0_ZERO_EN
        v[0] = 1'b0;
`endif
        return v;
    endfunction

    function automatic logic [31:0] mk(input int op, input int ra, input int rb, input int rc);
        logic [31:0] w;
        w = '0;
        w[31:27] = 5'(op);
        w[26:23] = 4'(ra);
        w[22:19] = 4'(rb);
        w[18:15] = 4'(rc);
        return w;
    endfunction

    // Reference: the execute steps (T3 onward) an instruction word must produce.
    task automatic build(input logic [31:0] w);
        int   op, ra, rb, rc, cls, ab;
        bit   bad;
        exp_t r;
        op = int'(w[31:27]);
        ra = int'(w[26:23]);
        rb = int'(w[22:19]);
        rc = int'(w[18:15]);
        cls = -1;
        ab  = 0;
        case (op)
            3:  begin cls = 0; ab = 2;  end
            4:  begin cls = 0; ab = 3;  end
            5:  begin cls = 0; ab = 0;  end
            6:  begin cls = 0; ab = 1;  end
            7:  begin cls = 0; ab = 9;  end
            8:  begin cls = 0; ab = 10; end
            9:  begin cls = 0; ab = 6;  end
            10: begin cls = 0; ab = 7;  end
            11: begin cls = 0; ab = 8;  end
            15: begin cls = 2; ab = 4;  end
            16: begin cls = 2; ab = 5;  end
            17: begin cls = 1; ab = 11; end
            18: begin cls = 1; ab = 12; end
            default: cls = -1;
        endcase
        bad = (cls < 0) || (ra >= NR) || (rb >= NR) || (cls == 0 && rc >= NR);
        steps.delete();
        if (bad) begin
            r = blank(); r.done = 1'b1; r.ill = 1'b1; steps.push_back(r);
        end else if (cls == 0) begin
            r = blank(); r.rout = oh(rb); r.stb[Y_IN] = 1'b1; steps.push_back(r);
            r = blank(); r.rout = oh(rc); r.alu[ab] = 1'b1; r.stb[Z_IN] = 1'b1; steps.push_back(r);
            r = blank(); r.stb[ZLOW] = 1'b1; r.rin = oh(ra); r.done = 1'b1; steps.push_back(r);
        end else if (cls == 1) begin
            r = blank(); r.rout = oh(rb); r.alu[ab] = 1'b1; r.stb[Z_IN] = 1'b1; steps.push_back(r);
            r = blank(); r.stb[ZLOW] = 1'b1; r.rin = oh(ra); r.done = 1'b1; steps.push_back(r);
        end else begin
            r = blank(); r.rout = oh(ra); r.stb[Y_IN] = 1'b1; steps.push_back(r);
            r = blank(); r.rout = oh(rb); r.alu[ab] = 1'b1; r.stb[Z_IN] = 1'b1; steps.push_back(r);
            r = blank(); r.stb[ZLOW] = 1'b1; r.stb[LO_IN] = 1'b1; steps.push_back(r);
            r = blank(); r.stb[ZHIGH] = 1'b1; r.stb[HI_IN] = 1'b1; r.done = 1'b1; steps.push_back(r);
        end
    endtask

    // Issue one instruction from an IDLE cycle; abort_at >= 0 pulls reset in that execute step.
    task automatic run_instr(input logic [31:0] w, input int stall, input int abort_at);
        exp_t r;
        build(w);
        start = 1'b1; mem_rdy = 1'($urandom); ir = $urandom;
        tick();
        r = blank();
        r.stb[PC_OUT] = 1'b1; r.stb[MAR_IN] = 1'b1; r.stb[INC_PC] = 1'b1; r.stb[Z_IN] = 1'b1;
        sb_q.push_back(r);
        start = 1'($urandom); mem_rdy = 1'($urandom);
        tick();
        for (int i = 0; i <= stall; i++) begin
            r = blank();
            r.stb[ZLOW] = 1'b1; r.stb[PC_IN] = 1'b1; r.stb[READ] = 1'b1; r.stb[MDR_IN] = 1'b1;
            sb_q.push_back(r);
            mem_rdy = (i == stall);
            start = 1'($urandom);
            tick();
        end
        r = blank();
        r.stb[MDR_OUT] = 1'b1; r.stb[IR_IN] = 1'b1;
        sb_q.push_back(r);
        ir = w; mem_rdy = 1'($urandom); start = 1'($urandom);
        tick();
        for (int j = 0; j < steps.size(); j++) begin
            if (j == abort_at) begin
                reset = 1'b0; start = 1'b0; n_done = '0;
                tick();
                reset = 1'b1;
                return;
            end
            sb_q.push_back(steps[j]);
            start = 1'($urandom); mem_rdy = 1'($urandom);
            tick();
        end
        n_done = n_done + CW'(1);
        start = 1'b0;
    endtask

    // Monitor: compares every cycle; busy cycles consume one scoreboard entry.
    always @(negedge clk) begin : mon
        exp_t a, e;
        a.rout = reg_out;
        a.rin  = reg_in;
        a.stb  = {lo_in, hi_in, zhigh_out, zlow_out, z_in, y_in, ir_in, read,
                  mdr_out, mdr_in, mar_in, inc_pc, pc_in, pc_out};
        a.alu  = alu_op;
        a.done = done;
        a.ill  = illegal;
        a.cnt  = instr_count;
        if (!reset) idle_cnt = '0;
        if (end_req) begin
            checks++;
            if (sb_q.size() != 0) begin
                errs++;
                $display("FAIL leftover_steps: %0d expected steps never seen, required 0", sb_q.size());
            end
            $display("Result: errors=%0d of %0d checks", errs, checks);
            $finish;
        end else if (busy) begin
            checks++;
            if (sb_q.size() == 0) begin
                errs++;
                $display("FAIL busy_unexpected: busy=1 act=%h, required idle", a);
            end else begin
                e = sb_q.pop_front();
                if (a !== e) begin
                    errs++;
                    $display("FAIL step @%0t: act=%h required=%h", $time, a, e);
                end
                if (e.done) idle_cnt = e.cnt + CW'(1);
            end
        end else begin
            checks++;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                errs++;
                $display("FAIL not_busy @%0t: busy=0 act=%h required=%h", $time, a, e);
                if (e.done) idle_cnt = e.cnt + CW'(1);
            end else begin
                e = '0;
                e.cnt = idle_cnt;
                if (a !== e) begin
                    errs++;
                    $display("FAIL idle @%0t: act=%h required=%h", $time, a, e);
                end
            end
        end
    end

    initial begin : stim
        logic [31:0] w;
        int ops[13] = '{3, 4, 5, 6, 7, 8, 9, 10, 11, 15, 16, 17, 18};
        reset = 1'b1; start = 1'b0; mem_rdy = 1'b0; ir = '0;
        n_done = '0; end_req = 1'b0;
        #1 reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();

        run_instr(32'h8A800000, 0, -1);           // NEG R5,R0
        tick();
        run_instr(32'h19238000, 0, -1);           // ADD R2,R4,R7
        run_instr(32'h79880000, 0, -1);           // MUL R3,R1
        run_instr(32'h19238000, 3, -1);           // ADD with 3 wait cycles in T1
        run_instr(32'hF8000000, 0, -1);           // undecodable opcode
        run_instr(mk(3, 3, 3, 3), 1, -1);         // aliased registers
        run_instr(mk(3, 13, 1, 2), 0, -1);        // Ra beyond register file
        run_instr(mk(4, 1, 2, NR), 0, -1);        // Rc just past the last register
        run_instr(mk(16, NR-1, NR-1, 15), 0, -1); // DIV, last register, unused Rc
        run_instr(32'h19238000, 0, 1);            // reset during T4
        run_instr(32'h88080000, 0, -1);           // NEG R0,R1
        tick();

        for (int k = 0; k < 70; k++) begin
            int op;
            op = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31))
                                             : ops[$urandom_range(0, 12)];
            w = $urandom;
            w[31:27] = 5'(op);
            w[26:23] = 4'(($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(0, NR-1));
            w[22:19] = 4'(($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(0, NR-1));
            w[18:15] = 4'(($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(0, NR-1));
            run_instr(w, int'($urandom_range(0, 3)), -1);
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (3) tick();
        end_req = 1'b1;
    end

endmodule
